// File: rtl/ps2_pkg.sv
// Shared scancode constants, receiver state encoding and digit decode for PS/2 operand entry.
// Pure definitions, no timing; nothing here applies backpressure.
package ps2_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_BS    = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Returns {valid, value}; valid is 0 for anything that is not a digit key.
  function automatic logic [4:0] digit_of(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      SC_0:    r = {1'b1, 4'd0};
      SC_1:    r = {1'b1, 4'd1};
      SC_2:    r = {1'b1, 4'd2};
      SC_3:    r = {1'b1, 4'd3};
      SC_4:    r = {1'b1, 4'd4};
      SC_5:    r = {1'b1, 4'd5};
      SC_6:    r = {1'b1, 4'd6};
      SC_7:    r = {1'b1, 4'd7};
      SC_8:    r = {1'b1, 4'd8};
      SC_9:    r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_operand_entry_if.sv
// Keyboard pins plus operand/debug outputs of the PS/2 operand entry block.
// master = keyboard/consumer side, slave = the entry block itself.
interface ps2_operand_entry_if;
  logic       kb_clk;
  logic       kb_data;
  logic [7:0] operand;
  logic       operand_valid;
  logic [7:0] scancode;
  logic       frame_err;

  modport master (
    output kb_clk, kb_data,
    input  operand, operand_valid, scancode, frame_err
  );

  modport slave (
    input  kb_clk, kb_data,
    output operand, operand_valid, scancode, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-flop sync, falling-edge detect, start/8 data/odd parity/stop check, idle timeout.
// byte_rdy/err are registered pulses one cycle after the deciding edge; no backpressure (keyboard cannot be stalled).
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic       byte_rdy,
  output logic [7:0] rx_byte,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_q;
  logic          dat_s1, dat_s2;
  logic          fell;
  rx_state_t     state, state_nx;
  logic [2:0]    cnt, cnt_nx;
  logic [7:0]    sr, sr_nx;
  logic          par_bad, par_bad_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          rdy_nx, err_nx;

  assign fell    = clk_q & ~clk_s2;
  assign rx_byte = sr;

  // Sync flops reset high so a reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_q    <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      sr       <= '0;
      par_bad  <= 1'b0;
      tmo      <= '0;
      byte_rdy <= 1'b0;
      err      <= 1'b0;
    end else begin
      clk_s1   <= kb_clk;
      clk_s2   <= clk_s1;
      clk_q    <= clk_s2;
      dat_s1   <= kb_data;
      dat_s2   <= dat_s1;
      state    <= state_nx;
      cnt      <= cnt_nx;
      sr       <= sr_nx;
      par_bad  <= par_bad_nx;
      tmo      <= tmo_nx;
      byte_rdy <= rdy_nx;
      err      <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sr_nx      = sr;
    par_bad_nx = par_bad;
    tmo_nx     = tmo;
    rdy_nx     = 1'b0;
    err_nx     = 1'b0;

    if (fell) begin
      tmo_nx = '0;
    end else if (state != RX_IDLE) begin
      if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nx = RX_IDLE;
        tmo_nx   = '0;
      end else begin
        tmo_nx = tmo + TW'(1);
      end
    end

    if (fell) begin
      case (state)
        RX_IDLE: begin
          if (!dat_s2) begin
            state_nx = RX_SHIFT;
            cnt_nx   = 3'd0;
          end else begin
            err_nx = 1'b1;
          end
        end
        RX_SHIFT: begin
          sr_nx  = {dat_s2, sr[7:1]};
          cnt_nx = cnt + 3'd1;
          if (cnt == 3'd7) state_nx = RX_PARITY;
        end
        RX_PARITY: begin
          // Parity error is flagged now; the stop bit then only realigns.
          par_bad_nx = ~(^{sr, dat_s2});
          err_nx     = par_bad_nx;
          state_nx   = RX_STOP;
        end
        RX_STOP: begin
          state_nx = RX_IDLE;
          if (!par_bad) begin
            if (dat_s2) rdy_nx = 1'b1;
            else        err_nx = 1'b1;
          end
        end
        default: state_nx = RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_operand_entry.sv
// PS/2 keypad to 8-bit decimal operand: decodes set-2 make codes, saturating accumulate, commit on Enter.
// operand/operand_valid/scancode update one cycle after byte_rdy; no backpressure, operand_valid is a 1-cycle pulse.
module ps2_operand_entry
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 rst,
  ps2_operand_entry_if.slave  bus
);

  logic        byte_rdy, rx_err;
  logic [7:0]  rx_byte;
  logic [7:0]  acc, acc_nx;
  logic        brk, brk_nx;
  logic        ext, ext_nx;
  logic [7:0]  operand, operand_nx;
  logic        valid_nx;
  logic [7:0]  scancode, scancode_nx;
  logic        operand_valid;
  logic [4:0]  dig;
  logic [11:0] acc_wide;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .kb_clk   (bus.kb_clk),
    .kb_data  (bus.kb_data),
    .byte_rdy (byte_rdy),
    .rx_byte  (rx_byte),
    .err      (rx_err)
  );

  assign dig      = digit_of(rx_byte);
  assign acc_wide = 12'(acc) * 12'd10 + 12'(dig[3:0]);

  assign bus.operand       = operand;
  assign bus.operand_valid = operand_valid;
  assign bus.scancode      = scancode;
  assign bus.frame_err     = rx_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      brk           <= 1'b0;
      ext           <= 1'b0;
      operand       <= '0;
      operand_valid <= 1'b0;
      scancode      <= '0;
    end else begin
      acc           <= acc_nx;
      brk           <= brk_nx;
      ext           <= ext_nx;
      operand       <= operand_nx;
      operand_valid <= valid_nx;
      scancode      <= scancode_nx;
    end
  end

  always_comb begin
    acc_nx      = acc;
    brk_nx      = brk;
    ext_nx      = ext;
    operand_nx  = operand;
    valid_nx    = 1'b0;
    scancode_nx = scancode;

    if (rx_err) begin
      brk_nx = 1'b0;
      ext_nx = 1'b0;
    end else if (byte_rdy) begin
      scancode_nx = rx_byte;
      if (rx_byte == SC_BRK) begin
        brk_nx = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_nx = 1'b1;
      end else begin
        brk_nx = 1'b0;
        ext_nx = 1'b0;
        // Extended codes (E0 xx) decode like plain ones, so ext only needs clearing.
        if (!brk) begin
          if (dig[4]) begin
            acc_nx = (acc_wide > 12'd255) ? 8'hFF : acc_wide[7:0];
          end else if (rx_byte == SC_BS) begin
            acc_nx = '0;
          end else if (rx_byte == SC_ENTER) begin
            operand_nx = acc;
            valid_nx   = 1'b1;
            acc_nx     = '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_operand_entry.sv
// Self-checking bench: bit-bangs PS/2 frames, expected operands queued at Enter and popped on operand_valid.
module tb_ps2_operand_entry;

  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_err = 0;
  int   err0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_operand_entry_if bus();

  ps2_operand_entry #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.kb_data = b;
    wait_clk(4);
    bus.kb_clk = 1'b0;
    wait_clk(8);
    bus.kb_clk = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    send_bit(1'b1);
    wait_clk(6);
  endtask

  task automatic key(input logic [7:0] code);
    send_frame(code, 1'b0);
  endtask

  task automatic enter(input logic [7:0] exp);
    exp_q.push_back(exp);
    key(8'h5A);
  endtask

  always @(negedge clk) begin
    if (bus.operand_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
      else chk("operand", bus.operand, exp_q.pop_front());
    end
    if (bus.frame_err === 1'b1) n_err++;
  end

  initial begin
    bus.kb_clk  = 1'b1;
    bus.kb_data = 1'b1;
    wait_clk(3);
    @(negedge clk);
    chk("rst_operand",  bus.operand, 0);
    chk("rst_valid",    bus.operand_valid, 0);
    chk("rst_scancode", bus.scancode, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    wait_clk(5);

    // 1,2,3 with break codes, then Enter
    key(8'h16); key(8'hF0); key(8'h16);
    key(8'h1E); key(8'hF0); key(8'h1E);
    key(8'h26); key(8'hF0); key(8'h26);
    enter(8'd123);
    chk("sc_after_enter", bus.scancode, 8'h5A);
    key(8'hF0); key(8'h5A);
    wait_clk(10);
    chk("q_empty_t1", exp_q.size(), 0);

    // saturation, then empty Enter
    key(8'h46); key(8'h46); key(8'h46);
    enter(8'd255);
    enter(8'd0);

    // 8, BS, 5, keypad Enter
    key(8'h3E); key(8'h66); key(8'h2E);
    key(8'hE0);
    chk("sc_ext", bus.scancode, 8'hE0);
    enter(8'd5);

    // bad parity
    err0 = n_err;
    send_frame(8'h1E, 1'b1);
    wait_clk(10);
    chk("perr_pulse", n_err, err0 + 1);
    chk("perr_scancode", bus.scancode, 8'h5A);
    key(8'h16);
    enter(8'd1);

    // partial frame abandoned by timeout
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wait_clk(TMO + 50);
    key(8'h46);
    chk("sc_digit9", bus.scancode, 8'h46);
    enter(8'd9);
    chk("tmo_no_err", n_err, err0 + 1);

    // reset mid-frame after digit 7
    key(8'h3D);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_operand",  bus.operand, 0);
    chk("mrst_valid",    bus.operand_valid, 0);
    chk("mrst_scancode", bus.scancode, 0);
    chk("mrst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    wait_clk(10);
    key(8'h25);
    enter(8'd4);

    wait_clk(30);
    chk("q_empty_end", exp_q.size(), 0);
    chk("total_frame_err", n_err, 1);
    chk("final_operand", bus.operand, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
